// File: rtl/ahb_lite_decoder_mux_pkg.sv
// Shared types for the AHB-Lite decoder/mux slice: transfer and
// response encodings, default-slave states and the miss counter width.
package ahb_lite_decoder_mux_pkg;

   typedef enum logic [1:0] {
      TRANS_IDLE   = 2'b00,
      TRANS_BUSY   = 2'b01,
      TRANS_NONSEQ = 2'b10,
      TRANS_SEQ    = 2'b11
   } HTRANS_E;

   typedef enum logic {
      RESP_OKAY  = 1'b0,
      RESP_ERROR = 1'b1
   } HRESP_E;

   typedef enum logic [1:0] {
      DS_IDLE,
      DS_ERR1,
      DS_ERR2
   } DS_STATE_E;

   localparam int MISS_CNT_W = 16;

   function automatic logic is_active(input HTRANS_E t);
      return (t == TRANS_NONSEQ) || (t == TRANS_SEQ);
   endfunction

endpackage

// File: rtl/ahb_lite_decoder_mux_if.sv
// AHB-Lite bus bundle between the master, the decoder/mux and the slaves.
// The slave modport is the interconnect's view; master is the driver's view.
interface ahb_lite_decoder_mux_if #(
   parameter int NUM_SLAVES = 3
);
   import ahb_lite_decoder_mux_pkg::*;

   logic [31:0]              HADDR;
   HTRANS_E                  HTRANS;
   logic [NUM_SLAVES-1:0]    HSEL;
   logic [NUM_SLAVES*32-1:0] HRDATA_S;
   logic [NUM_SLAVES-1:0]    HREADYOUT_S;
   logic [NUM_SLAVES-1:0]    HRESP_S;
   logic                     HREADY;
   HRESP_E                   HRESP;
   logic [31:0]              HRDATA;

   modport slave (
      input  HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
      output HSEL, HREADY, HRESP, HRDATA
   );

   modport master (
      output HADDR, HTRANS, HRDATA_S, HREADYOUT_S, HRESP_S,
      input  HSEL, HREADY, HRESP, HRDATA
   );

endinterface

// File: rtl/ahb_default_slave.sv
// Default slave: two-cycle ERROR for active unmapped transfers.
// Optional saturating miss counter under DECODE_MISS_CNT_EN.
module ahb_default_slave
   import ahb_lite_decoder_mux_pkg::*;
(
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HREADY,
   input  logic                  miss_req,
   output logic                  ds_hready,
   output HRESP_E                ds_hresp,
   output logic [MISS_CNT_W-1:0] MISS_COUNT
);

   DS_STATE_E state_q, state_d;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DS_IDLE: if (HREADY && miss_req) state_d = DS_ERR1;
         DS_ERR1: state_d = DS_ERR2;
         DS_ERR2: state_d = (HREADY && miss_req) ? DS_ERR1 : DS_IDLE;
         default: state_d = DS_IDLE;
      endcase
   end

   // Kept apart from next-state logic: HREADY loops back through the top mux.
   assign ds_hready = (state_q != DS_ERR1);
   assign ds_hresp  = (state_q == DS_IDLE) ? RESP_OKAY : RESP_ERROR;

   always_ff @(posedge HCLK) begin
      if (!HRESETn) state_q <= DS_IDLE;
      else          state_q <= state_d;
   end

`ifdef DECODE_MISS_CNT_EN
   logic [MISS_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (state_d == DS_ERR1 && state_q != DS_ERR1 && cnt_q != '1)
         cnt_d = cnt_q + MISS_CNT_W'(1);
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign MISS_COUNT = cnt_q;
`else
   assign MISS_COUNT = '0;
`endif

endmodule

// File: rtl/ahb_lite_decoder_mux.sv
// AHB-Lite address decoder and response mux with a built-in default slave.
// Build with DECODE_MISS_CNT_EN to get the unmapped-access counter.
module ahb_lite_decoder_mux
   import ahb_lite_decoder_mux_pkg::*;
#(
   parameter int NUM_SLAVES = 3,
   parameter int SEL_LSB    = 8,
   parameter int SEL_W      = 2
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   ahb_lite_decoder_mux_if.slave bus,
   output logic [MISS_CNT_W-1:0] MISS_COUNT
);

   localparam logic [SEL_W-1:0] DEFAULT_SEL = '1;

   logic [SEL_W-1:0]      idx;
   logic                  mapped;
   logic                  active;
   logic [NUM_SLAVES-1:0] hsel;

   logic [SEL_W-1:0] dsel_q, dsel_d;
   logic             dactive_q, dactive_d;

   logic        hready;
   HRESP_E      hresp;
   logic [31:0] hrdata;
   logic        ds_hready;
   HRESP_E      ds_hresp;

   assign idx    = bus.HADDR[SEL_LSB+SEL_W-1:SEL_LSB];
   assign active = is_active(bus.HTRANS);

   // Written as an if so an unknown address falls to unmapped.
   always_comb begin
      mapped = 1'b0;
      if (bus.HADDR[31:SEL_LSB+SEL_W] == '0 && int'(idx) < NUM_SLAVES)
         mapped = 1'b1;
   end

   always_comb begin
      hsel = '0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (mapped && idx == SEL_W'(i)) hsel[i] = 1'b1;
   end

   always_comb begin
      dsel_d    = dsel_q;
      dactive_d = dactive_q;
      if (hready) begin
         dsel_d    = mapped ? idx : DEFAULT_SEL;
         dactive_d = active;
      end
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         dsel_q    <= DEFAULT_SEL;
         dactive_q <= 1'b0;
      end else begin
         dsel_q    <= dsel_d;
         dactive_q <= dactive_d;
      end
   end

   // DEFAULT_SEL never matches a mapped slave, so it falls to the default.
   always_comb begin
      hready = ds_hready;
      hresp  = ds_hresp;
      hrdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (dsel_q == SEL_W'(i)) begin
            hready = bus.HREADYOUT_S[i];
            hresp  = bus.HRESP_S[i] ? RESP_ERROR : RESP_OKAY;
            hrdata = bus.HRDATA_S[32*i +: 32];
         end
      end
   end

   ahb_default_slave u_ds (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .HREADY     (hready),
      .miss_req   (!mapped && active),
      .ds_hready  (ds_hready),
      .ds_hresp   (ds_hresp),
      .MISS_COUNT (MISS_COUNT)
   );

   assign bus.HSEL   = hsel;
   assign bus.HREADY = hready;
   assign bus.HRESP  = hresp;
   assign bus.HRDATA = hrdata;

   a_err_has_active: assert property (
      @(posedge HCLK) disable iff (!HRESETn)
      (ds_hresp == RESP_ERROR) |-> (dactive_q && dsel_q == DEFAULT_SEL)
   );

endmodule

// File: tb/tb_ahb_lite_decoder_mux.sv
// Directed bench for ahb_lite_decoder_mux with a tiny slave-1 memory model.
// Miss-count expectations follow DECODE_MISS_CNT_EN.
module tb_ahb_lite_decoder_mux;
   import ahb_lite_decoder_mux_pkg::*;

`ifdef DECODE_MISS_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic [15:0] miss_count;
   logic        hwrite;
   logic [31:0] hwdata;
   logic [31:0] s1_reg;
   logic        s1_dp;
   logic        s1_dw;

   int n_checks;
   int n_errors;

   ahb_lite_decoder_mux_if #(.NUM_SLAVES(3)) bus ();

   ahb_lite_decoder_mux #(
      .NUM_SLAVES (3),
      .SEL_LSB    (8),
      .SEL_W      (2)
   ) dut (
      .HCLK       (clk),
      .HRESETn    (rst_n),
      .bus        (bus),
      .MISS_COUNT (miss_count)
   );

   assign bus.HRDATA_S = {32'h2222_2222, s1_reg, 32'h1111_1111};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Slave 1: stores the write word at the end of its data phase.
   always @(posedge clk) begin
      if (bus.HREADY) begin
         if (s1_dp && s1_dw) s1_reg <= hwdata;
         s1_dp <= bus.HSEL[1] && is_active(bus.HTRANS);
         s1_dw <= hwrite;
      end
   end

   task automatic check(input string tag,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] exp_miss(input int n);
      return CNT_EN ? 32'(n) : 32'h0;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_errors = 0;
      s1_reg = '0;
      s1_dp  = 1'b0;
      s1_dw  = 1'b0;
      hwrite = 1'b0;
      hwdata = '0;
      rst_n  = 1'b0;
      bus.HADDR       = 32'h0000_0300;
      bus.HTRANS      = TRANS_NONSEQ;
      bus.HREADYOUT_S = 3'b111;
      bus.HRESP_S     = 3'b000;

      // Reset with an active unmapped request pending
      repeat (2) step();
      check("rst_hready", 32'(bus.HREADY), 32'h1);
      check("rst_hresp",  32'(bus.HRESP),  32'h0);
      check("rst_hrdata", bus.HRDATA,      32'h0);
      check("rst_miss",   32'(miss_count), 32'h0);
      check("rst_hsel",   32'(bus.HSEL),   32'h0);

      rst_n = 1'b1;
      bus.HTRANS = TRANS_IDLE;
      bus.HADDR  = 32'h0;
      step();

      // Mapped write then read on slave 1
      bus.HADDR  = 32'h0000_0104;
      bus.HTRANS = TRANS_NONSEQ;
      hwrite = 1'b1;
      #1;
      check("wr_hsel", 32'(bus.HSEL), 32'h2);
      step();
      hwdata = 32'hCAFE_F00D;
      hwrite = 1'b0;
      #1;
      check("rd_hsel",   32'(bus.HSEL),   32'h2);
      check("wr_hready", 32'(bus.HREADY), 32'h1);
      check("wr_hresp",  32'(bus.HRESP),  32'h0);
      step();
      bus.HTRANS = TRANS_IDLE;
      bus.HADDR  = 32'h0;
      #1;
      check("rd_hrdata", bus.HRDATA,      32'hCAFE_F00D);
      check("rd_hresp",  32'(bus.HRESP),  32'h0);
      check("rd_hready", 32'(bus.HREADY), 32'h1);
      step();

      // Unmapped active transfer
      bus.HADDR  = 32'h0000_0300;
      bus.HTRANS = TRANS_NONSEQ;
      #1;
      check("um_hsel", 32'(bus.HSEL), 32'h0);
      step();
      bus.HTRANS = TRANS_IDLE;
      bus.HADDR  = 32'h0;
      #1;
      check("um1_hready", 32'(bus.HREADY), 32'h0);
      check("um1_hresp",  32'(bus.HRESP),  32'h1);
      check("um1_hrdata", bus.HRDATA,      32'h0);
      check("um1_miss",   32'(miss_count), exp_miss(1));
      step();
      check("um2_hready", 32'(bus.HREADY), 32'h1);
      check("um2_hresp",  32'(bus.HRESP),  32'h1);
      step();
      check("um_done_hresp",  32'(bus.HRESP), 32'h0);
      check("um_done_hrdata", bus.HRDATA,     32'h1111_1111);

      // Unmapped IDLE: zero-wait OKAY
      bus.HADDR = 32'h1000_0104;
      #1;
      check("hi_bits_hsel", 32'(bus.HSEL), 32'h0);
      bus.HADDR = 32'h1000_0000;
      #1;
      check("ui_hsel", 32'(bus.HSEL), 32'h0);
      step();
      check("ui_hready", 32'(bus.HREADY), 32'h1);
      check("ui_hresp",  32'(bus.HRESP),  32'h0);
      check("ui_hrdata", bus.HRDATA,      32'h0);
      check("ui_miss",   32'(miss_count), exp_miss(1));

      // Wait states from slave 2 hold the data phase
      bus.HADDR  = 32'h0000_0200;
      bus.HTRANS = TRANS_NONSEQ;
      #1;
      check("ws_hsel", 32'(bus.HSEL), 32'h4);
      step();
      bus.HREADYOUT_S = 3'b011;
      bus.HADDR = 32'h0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("ws_hready", 32'(bus.HREADY), 32'h0);
         check("ws_hrdata", bus.HRDATA,      32'h2222_2222);
         step();
      end
      bus.HREADYOUT_S = 3'b111;
      #1;
      check("ws_rel_hready", 32'(bus.HREADY), 32'h1);
      check("ws_rel_hrdata", bus.HRDATA,      32'h2222_2222);
      step();

      // Slave-0 ERROR passes through
      bus.HTRANS  = TRANS_IDLE;
      bus.HRESP_S = 3'b001;
      #1;
      check("s0_hresp",  32'(bus.HRESP), 32'h1);
      check("s0_hrdata", bus.HRDATA,     32'h1111_1111);
      bus.HRESP_S = 3'b000;
      step();

      // Back-to-back unmapped, then reset during second ERR1
      bus.HADDR  = 32'h0000_0300;
      bus.HTRANS = TRANS_NONSEQ;
      step();
      bus.HADDR  = 32'h0000_0304;
      bus.HTRANS = TRANS_SEQ;
      #1;
      check("bb1_hready", 32'(bus.HREADY), 32'h0);
      check("bb1_miss",   32'(miss_count), exp_miss(2));
      step();
      check("bb2_hready", 32'(bus.HREADY), 32'h1);
      check("bb2_hresp",  32'(bus.HRESP),  32'h1);
      step();
      bus.HTRANS = TRANS_IDLE;
      #1;
      check("bb3_hready", 32'(bus.HREADY), 32'h0);
      check("bb3_hresp",  32'(bus.HRESP),  32'h1);
      check("bb3_miss",   32'(miss_count), exp_miss(3));
      rst_n = 1'b0;
      step();
      check("rs_hready", 32'(bus.HREADY), 32'h1);
      check("rs_hresp",  32'(bus.HRESP),  32'h0);
      check("rs_hrdata", bus.HRDATA,      32'h0);
      check("rs_miss",   32'(miss_count), 32'h0);
      rst_n = 1'b1;

      // Mapped address accepted during ERR2
      bus.HADDR  = 32'h0000_0300;
      bus.HTRANS = TRANS_NONSEQ;
      step();
      bus.HADDR = 32'h0000_0004;
      step();
      check("m2_hsel",   32'(bus.HSEL),   32'h1);
      check("m2_hready", 32'(bus.HREADY), 32'h1);
      check("m2_hresp",  32'(bus.HRESP),  32'h1);
      step();
      bus.HTRANS = TRANS_IDLE;
      #1;
      check("m2_hrdata",  bus.HRDATA,      32'h1111_1111);
      check("m2_dp_resp", 32'(bus.HRESP),  32'h0);
      check("m2_dp_rdy",  32'(bus.HREADY), 32'h1);
      check("m2_miss",    32'(miss_count), exp_miss(1));

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ahb_lite_decoder_mux.md
Name: ahb_lite_decoder_mux

Overview:
Interconnect stage between the AHB-Lite master and the slave_N instances. Decodes HADDR into one-hot HSEL during the address phase and registers the selection for the data phase. Multiplexes the selected slave's HRDATA, HREADYOUT and HRESP back to the master. Contains a default slave that returns a two-cycle ERROR response for active transfers to unmapped addresses.

Parameters:
NUM_SLAVES, 3, number of mapped slaves (1..2**SEL_W-1); slave indices at or above NUM_SLAVES are unmapped.
SEL_LSB, 8, lowest HADDR bit of the slave index field (256-byte region per slave).
SEL_W, 2, width of the slave index field HADDR[SEL_LSB+SEL_W-1:SEL_LSB].

Ports:
HCLK  in  1  system clock; all state updates on its rising edge.
HRESETn  in  1  synchronous, active-low reset.
HADDR  in  32  master address.
HTRANS  in  HTRANS_E  master transfer type.
HSEL  out  NUM_SLAVES  one-hot slave select, address phase.
HRDATA_S  in  NUM_SLAVES*32  concatenated slave read data; slave i occupies bits [32i+31:32i].
HREADYOUT_S  in  NUM_SLAVES  per-slave HREADY.
HRESP_S  in  NUM_SLAVES  per-slave response; 1 = ERROR, 0 = OKAY.
HREADY  out  1  muxed ready to master and slaves.
HRESP  out  HRESP_E  muxed response to master.
HRDATA  out  32  muxed read data to master.
MISS_COUNT  out  16  unmapped-access count (see Optional Feature).

Behaviour:
- Clock and reset: one clock, HCLK. HRESETn is synchronous and active-low; it is sampled only on the rising edge of HCLK.
- Decode (combinational): idx = HADDR[SEL_LSB+SEL_W-1:SEL_LSB].
  - A location is mapped iff idx < NUM_SLAVES and HADDR[31:SEL_LSB+SEL_W] == 0.
  - HSEL[idx] = 1 iff mapped. HSEL does not depend on HTRANS; slaves qualify HTRANS themselves.
- Data-phase register: on an edge where HREADY == 1, capture:
  - dsel = idx, or DEFAULT if unmapped;
  - dactive = (HTRANS == NONSEQ or HTRANS == SEQ).
  When HREADY == 0, both hold their values.
- Response mux:
  - dsel mapped: HREADY = HREADYOUT_S[dsel]; HRESP = ERROR if HRESP_S[dsel] else OKAY; HRDATA = slice dsel of HRDATA_S.
  - dsel == DEFAULT: HREADY and HRESP come from the default-slave FSM; HRDATA = 0.
- Default-slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: HREADY = 1, HRESP = OKAY. Moves to DS_ERR1 when HREADY == 1, the address is unmapped and HTRANS is NONSEQ or SEQ.
  - DS_ERR1: HREADY = 0, HRESP = ERROR. Always moves to DS_ERR2.
  - DS_ERR2: HREADY = 1, HRESP = ERROR. Next state is DS_ERR1 if a new unmapped active transfer is presented in this cycle, otherwise DS_IDLE.
  - An unmapped IDLE or BUSY transfer gets a zero-wait OKAY and leaves the FSM in DS_IDLE.
- Latency: address-to-HSEL is 0 cycles. A mapped response appears in the cycle after the address is accepted. An unmapped error takes exactly 2 data-phase cycles.
- Back-to-back: a mapped address presented during DS_ERR2 is accepted; the next data phase is served from that slave.
- Reset values (including assertion mid-operation, effective at the next edge): dsel = DEFAULT, dactive = 0, FSM = DS_IDLE, MISS_COUNT = 0. Resulting outputs: HREADY = 1, HRESP = OKAY, HRDATA = 0. HSEL stays combinational from HADDR.
- An X or illegal idx is treated as unmapped.

Optional Feature:
Macro: DECODE_MISS_CNT_EN.
- With the macro: MISS_COUNT increments by 1 on every DS_IDLE->DS_ERR1 or DS_ERR2->DS_ERR1 transition. It saturates at 16'hFFFF and is cleared by reset.
- Without the macro: the MISS_COUNT port remains but is tied to 16'h0000, and no counter flops are built.

Decomposition:
- master_package gains:
  - typedef enum DS_STATE_E {DS_IDLE, DS_ERR1, DS_ERR2};
  - localparam MISS_CNT_W = 16.
  It already holds HTRANS_E and HRESP_E, which are reused here.
- One sub-module, ahb_default_slave, contains the FSM and the optional miss counter.
  - Inputs: HCLK, HRESETn, HREADY, unmapped/active strobe.
  - Outputs: ds_hready, ds_hresp, MISS_COUNT.

Test Plan:
- Reset: hold HRESETn = 0 for 2 edges with HTRANS = NONSEQ, HADDR = 0x300 -> HREADY = 1, HRESP = OKAY, HRDATA = 0, FSM in DS_IDLE.
- Mapped write/read: NONSEQ write 0x0000_0104 (WORD), then NONSEQ read of the same address -> HSEL = 3'b010 in both address phases; HRDATA equals the written word on the slave-1 data phase; HRESP = OKAY.
- Unmapped active: NONSEQ read 0x0000_0300 -> HSEL = 0. Data cycle 1: HREADY = 0, HRESP = ERROR. Cycle 2: HREADY = 1, HRESP = ERROR. With DECODE_MISS_CNT_EN, MISS_COUNT = 1.
- Unmapped IDLE: HTRANS = IDLE, HADDR = 0x1000_0000 -> zero-wait OKAY, no FSM transition, MISS_COUNT unchanged.
- Wait-state hold: slave 2 drives HREADYOUT_S[2] = 0 for 3 cycles while the master changes HADDR to 0x000 -> dsel stays 2, and HREADY = 0 for those 3 cycles.
- Back-to-back: unmapped NONSEQ 0x300 followed by unmapped SEQ 0x304 presented in DS_ERR2 -> FSM goes ERR1, ERR2, ERR1, ERR2; MISS_COUNT = 2. Asserting reset during the second ERR1 -> DS_IDLE and MISS_COUNT = 0 at the next edge.
